// File: rtl/aemb_pipe_ctrl.sv
// AEMB pipeline sequencer: fetch, optional data wait, one-cycle execute enable.
// Define AEMB_BUS_TIMEOUT_EN to add the bus-timeout counter (exception code 2).
module aemb_pipe_ctrl #(
   parameter int TW = 4
) (
   input  logic       gclk,
   input  logic       grst,
   output logic       iwb_stb_o,
   input  logic       iwb_ack_i,
   input  logic       dwb_req_i,
   output logic       dwb_stb_o,
   input  logic       dwb_ack_i,
   input  logic       sys_int_i,
   input  logic       rMSR_IE,
   input  logic       rBRA,
   input  logic       rDLY,
   output logic       gena,
   output logic [1:0] rXCE
);

   typedef enum logic [1:0] {ST_RST, ST_FETCH, ST_DWAIT, ST_EXEC} state_t;

   state_t state;
   logic   irq_meta;
   logic   rIRQ;
   logic   tmo;
   logic   tmo_hit;

   if (TW < 1) begin : g_bad_tw
      $error("aemb_pipe_ctrl: TW must be at least 1");
   end

`ifdef AEMB_BUS_TIMEOUT_EN
   localparam logic [TW-1:0] CNT_TERM = '1;
   localparam logic [TW-1:0] CNT_ONE  = TW'(1);
   localparam logic [TW-1:0] CNT_LAST = CNT_TERM - CNT_ONE;

   logic [TW-1:0] cnt;
   logic          waiting;

   // Counter only runs while a strobe is out and unanswered; any other cycle clears it.
   assign waiting = ((state == ST_FETCH) && !iwb_ack_i) ||
                    ((state == ST_DWAIT) && !dwb_ack_i);
   assign tmo_hit = waiting && (cnt == CNT_LAST);

   always_ff @(posedge gclk) begin
      if (grst) begin
         cnt <= '0;
      end else if (waiting) begin
         if (cnt != CNT_TERM) cnt <= cnt + CNT_ONE;
      end else begin
         cnt <= '0;
      end
   end
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge gclk) begin
      if (grst) begin
         state     <= ST_RST;
         iwb_stb_o <= 1'b0;
         dwb_stb_o <= 1'b0;
         gena      <= 1'b0;
         tmo       <= 1'b0;
         irq_meta  <= 1'b0;
         rIRQ      <= 1'b0;
      end else begin
         irq_meta <= sys_int_i;
         rIRQ     <= irq_meta;
         case (state)
            ST_RST: begin
               state     <= ST_FETCH;
               iwb_stb_o <= 1'b1;
            end
            ST_FETCH: begin
               // An ack on the terminal-count cycle takes the normal path.
               if (iwb_ack_i) begin
                  iwb_stb_o <= 1'b0;
                  if (dwb_req_i) begin
                     state     <= ST_DWAIT;
                     dwb_stb_o <= 1'b1;
                  end else begin
                     state <= ST_EXEC;
                     gena  <= 1'b1;
                  end
               end else if (tmo_hit) begin
                  state     <= ST_EXEC;
                  iwb_stb_o <= 1'b0;
                  gena      <= 1'b1;
                  tmo       <= 1'b1;
               end
            end
            ST_DWAIT: begin
               if (dwb_ack_i) begin
                  state     <= ST_EXEC;
                  dwb_stb_o <= 1'b0;
                  gena      <= 1'b1;
               end else if (tmo_hit) begin
                  state     <= ST_EXEC;
                  dwb_stb_o <= 1'b0;
                  gena      <= 1'b1;
                  tmo       <= 1'b1;
               end
            end
            ST_EXEC: begin
               state     <= ST_FETCH;
               iwb_stb_o <= 1'b1;
               gena      <= 1'b0;
               tmo       <= 1'b0;
            end
            default: begin
               state     <= ST_RST;
               iwb_stb_o <= 1'b0;
               dwb_stb_o <= 1'b0;
               gena      <= 1'b0;
               tmo       <= 1'b0;
            end
         endcase
      end
   end

   // Interrupt qualifiers are evaluated in the execute cycle itself, so a blocked
   // request is naturally retaken at a later execute while rIRQ stays high.
   always_comb begin
      rXCE = 2'd0;
      if (state == ST_EXEC) begin
         if (tmo)
            rXCE = 2'd2;
         else if (rIRQ && rMSR_IE && !rBRA && !rDLY)
            rXCE = 2'd1;
      end
   end

endmodule

// File: tb/tb_aemb_pipe_ctrl.sv
// Self-checking bench for aemb_pipe_ctrl: directed scenarios plus randomized
// traffic compared each cycle against a transaction-level reference model.
module tb_aemb_pipe_ctrl;
   localparam int TW = 4;
`ifdef AEMB_BUS_TIMEOUT_EN
   localparam int LIMIT = (1 << TW) - 1;
`endif

   logic       gclk = 1'b0;
   logic       grst, iwb_stb_o, iwb_ack_i, dwb_req_i, dwb_stb_o, dwb_ack_i;
   logic       sys_int_i, rMSR_IE, rBRA, rDLY, gena;
   logic [1:0] rXCE;

   int n_chk = 0;
   int n_err = 0;

   always #5 gclk = ~gclk;

   aemb_pipe_ctrl #(.TW(TW)) dut (
      .gclk(gclk), .grst(grst),
      .iwb_stb_o(iwb_stb_o), .iwb_ack_i(iwb_ack_i),
      .dwb_req_i(dwb_req_i), .dwb_stb_o(dwb_stb_o), .dwb_ack_i(dwb_ack_i),
      .sys_int_i(sys_int_i), .rMSR_IE(rMSR_IE), .rBRA(rBRA), .rDLY(rDLY),
      .gena(gena), .rXCE(rXCE)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: 0 idle after reset, 1 waiting for instruction, 2 waiting
   // for data, 3 execute. irq_hist holds sys_int_i as seen at the last edges.
   int ph     = 0;
   int waited = 0;
   bit to_flag = 0;
   bit irq_hist[$];

   function automatic int exp_xce();
      bit irq;
      irq = (irq_hist.size() >= 2) ? irq_hist[1] : 1'b0;
      if (ph != 3) return 0;
      if (to_flag) return 2;
      if (irq && rMSR_IE && !rBRA && !rDLY) return 1;
      return 0;
   endfunction

   task automatic wait_cycle();
`ifdef AEMB_BUS_TIMEOUT_EN
      waited++;
      if (waited == LIMIT) begin
         ph      = 3;
         to_flag = 1;
      end
`endif
   endtask

   task automatic model_step();
      if (grst) begin
         ph = 0; waited = 0; to_flag = 0;
         irq_hist.delete();
         return;
      end
      irq_hist.push_front(sys_int_i);
      if (irq_hist.size() > 2) void'(irq_hist.pop_back());
      case (ph)
         0: begin ph = 1; waited = 0; end
         1: if (iwb_ack_i) begin ph = dwb_req_i ? 2 : 3; waited = 0; end
            else wait_cycle();
         2: if (dwb_ack_i) ph = 3;
            else wait_cycle();
         default: begin ph = 1; waited = 0; to_flag = 0; end
      endcase
   endtask

   logic       o_iwb, o_dwb, o_gena;
   logic [1:0] o_xce;

   // Inputs are set at the falling edge; outputs sampled 1 ns later.
   task automatic tick();
      #1;
      o_iwb = iwb_stb_o; o_dwb = dwb_stb_o; o_gena = gena; o_xce = rXCE;
      check("iwb_stb", iwb_stb_o, 32'(ph == 1));
      check("dwb_stb", dwb_stb_o, 32'(ph == 2));
      check("gena", gena, 32'(ph == 3));
      check("rXCE", rXCE, exp_xce());
      @(posedge gclk);
      model_step();
      @(negedge gclk);
   endtask

   int n, fc, pct;

   initial begin
      grst = 1; iwb_ack_i = 0; dwb_req_i = 0; dwb_ack_i = 0;
      sys_int_i = 0; rMSR_IE = 0; rBRA = 0; rDLY = 0;
      o_gena = 0;
      @(posedge gclk);
      model_step();
      @(negedge gclk);
      tick();
      tick();
      check("reset_iwb", o_iwb, 0);
      check("reset_gena", o_gena, 0);
      grst = 0;

      // Ack on the second fetch cycle, no data access.
      fc = 0; n = 0; o_gena = 0;
      for (int i = 0; i < 12 && !o_gena; i++) begin
         iwb_ack_i = (ph == 1 && fc == 1);
         tick();
         if (o_iwb) fc++;
         if (fc > 0) n++;
      end
      iwb_ack_i = 0;
      check("fetch_to_gena", n, 3);

      // Data access acknowledged on its third wait cycle.
      dwb_req_i = 1; iwb_ack_i = 1;
      tick();
      iwb_ack_i = 0;
      n = 0;
      for (int k = 0; k < 3; k++) begin
         dwb_ack_i = (k == 2);
         tick();
         if (o_dwb) n++;
      end
      dwb_ack_i = 0; dwb_req_i = 0;
      tick();
      check("dwb_stb_len", n, 3);
      check("gena_after_data", o_gena, 1);

      // Interrupt blocked by a branch, then retaken.
      sys_int_i = 1; rMSR_IE = 1;
      tick(); tick(); tick();
      iwb_ack_i = 1; tick();
      iwb_ack_i = 0; rBRA = 1; tick();
      check("irq_blocked", o_xce, 0);
      rBRA = 0; iwb_ack_i = 1; tick();
      iwb_ack_i = 0; tick();
      check("irq_retaken", o_xce, 1);
      check("irq_exec_gena", o_gena, 1);

      // No instruction ack: timeout, or an indefinite wait without the counter.
      n = 0; o_gena = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (o_gena) break;
         if (o_iwb) n++;
      end
`ifdef AEMB_BUS_TIMEOUT_EN
      check("timeout_waits", n, LIMIT);
      check("timeout_xce", o_xce, 2);
      for (int i = 0; i < LIMIT - 1; i++) tick();
      iwb_ack_i = 1; tick();
      iwb_ack_i = 0; tick();
      check("ack_wins_gena", o_gena, 1);
      check("ack_wins_xce", o_xce, 1);
`else
      check("no_timeout_hold", n, 100);
      check("no_timeout_gena", o_gena, 0);
`endif

      // Reset in the middle of a data wait.
      sys_int_i = 0; dwb_req_i = 1; iwb_ack_i = 1; tick();
      iwb_ack_i = 0; tick();
      check("dwait_entered", o_dwb, 1);
      grst = 1; tick();
      grst = 0; dwb_ack_i = 1; tick();
      check("rst_dwb_drop", o_dwb, 0);
      check("rst_iwb", o_iwb, 0);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (o_gena) n++;
      end
      dwb_ack_i = 0; dwb_req_i = 0;
      check("rst_gena_quiet", n, 0);

      // Randomized traffic with dense, medium and sparse acknowledges.
      for (int blk = 0; blk < 6; blk++) begin
         pct = (blk % 3 == 0) ? 50 : (blk % 3 == 1) ? 20 : 3;
         for (int c = 0; c < 400; c++) begin
            grst      = ($urandom_range(0, 199) == 0);
            iwb_ack_i = ($urandom_range(0, 99) < pct);
            dwb_ack_i = ($urandom_range(0, 99) < pct);
            dwb_req_i = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) sys_int_i = ~sys_int_i;
            rMSR_IE   = ($urandom_range(0, 3) != 0);
            rBRA      = ($urandom_range(0, 3) == 0);
            rDLY      = ($urandom_range(0, 3) == 0);
            tick();
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/aemb_pipe_ctrl.md
AEMB_PIPE_CTRL -- requirements
Module: aemb_pipe_ctrl

Interface
REQ-001 SHALL have parameter TW, default 4: bus-timeout counter width; timeout after 2**TW-1 wait cycles.
REQ-002 SHALL have port gclk, input, 1: clock, all state updates on rising edge.
REQ-003 SHALL have port grst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port iwb_stb_o, output, 1: instruction-bus fetch strobe.
REQ-005 SHALL have port iwb_ack_i, input, 1: instruction-bus acknowledge.
REQ-006 SHALL have port dwb_req_i, input, 1: datapath has a load/store pending this instruction.
REQ-007 SHALL have port dwb_stb_o, output, 1: data-bus strobe.
REQ-008 SHALL have port dwb_ack_i, input, 1: data-bus acknowledge.
REQ-009 SHALL have port sys_int_i, input, 1: asynchronous level interrupt request.
REQ-010 SHALL have port rMSR_IE, input, 1: interrupt enable from machine status register.
REQ-011 SHALL have port rBRA, input, 1: branch taken in progress, from branch/PC unit.
REQ-012 SHALL have port rDLY, input, 1: delay slot pending, from branch/PC unit.
REQ-013 SHALL have port gena, output, 1: pipeline advance enable to all datapath units.
REQ-014 SHALL have port rXCE, output, 2: exception code; 0 none, 1 interrupt, 2 bus timeout.

Function
REQ-015 SHALL implement FSM states RST, FETCH, DWAIT, EXEC.
REQ-016 RST: all strobes 0, gena 0; SHALL go to FETCH next cycle unconditionally.
REQ-017 FETCH: iwb_stb_o=1; on iwb_ack_i SHALL go to DWAIT if dwb_req_i=1, else EXEC.
REQ-018 DWAIT: dwb_stb_o=1, iwb_stb_o=0; on dwb_ack_i SHALL go to EXEC.
REQ-019 EXEC: gena=1 for exactly one cycle, all strobes 0; SHALL go to FETCH next cycle.
REQ-020 gena SHALL be high only in EXEC; never two consecutive cycles.
REQ-021 Ack arriving outside its matching wait state SHALL be ignored.
REQ-022 sys_int_i SHALL pass a two-flop synchronizer; synchronized value rIRQ.
REQ-023 In EXEC, if rIRQ & rMSR_IE & !rBRA & !rDLY, rXCE SHALL be 1 for that cycle.
REQ-024 Interrupt blocked by rBRA or rDLY SHALL be retaken at first later EXEC where the condition holds and rIRQ still high.
REQ-025 rXCE SHALL be 0 outside EXEC; bus timeout (code 2) SHALL take priority over interrupt in the same EXEC.
REQ-026 Timeout counter SHALL clear on entry to FETCH or DWAIT, increment each wait cycle without ack, saturate.
REQ-027 Counter reaching 2**TW-1 SHALL force EXEC next cycle with rXCE=2, strobes dropped.
REQ-028 Ack in the same cycle as terminal count SHALL win: normal transition, rXCE not 2.

Reset
REQ-029 grst SHALL force state RST, rIRQ and synchronizer flops 0, counter 0, iwb_stb_o 0, dwb_stb_o 0, gena 0, rXCE 0.
REQ-030 grst mid-transaction SHALL drop strobes in the following cycle; outstanding acks discarded.

Configuration
REQ-031 Macro AEMB_BUS_TIMEOUT_EN defined: counter and REQ-026..028 present.
REQ-032 Macro AEMB_BUS_TIMEOUT_EN undefined: no counter logic; FETCH/DWAIT wait indefinitely; rXCE never 2.

Verification
REQ-033 Reset then iwb_ack_i on 2nd FETCH cycle, dwb_req_i=0 -> gena pulse 1 cycle; FETCH-to-gena period 3 cycles.
REQ-034 dwb_req_i=1, dwb_ack_i after 3 cycles -> dwb_stb_o high 3 cycles, then gena 1 cycle.
REQ-035 sys_int_i=1, rMSR_IE=1, rBRA=1 at first EXEC, 0 at next -> rXCE=0 then rXCE=1 at 2nd EXEC.
REQ-036 TW=4, macro defined, no iwb_ack_i -> EXEC after 15 wait cycles with rXCE=2; macro undefined -> iwb_stb_o held 100 cycles.
REQ-037 grst asserted during DWAIT -> dwb_stb_o 0 next cycle, state RST, late dwb_ack_i ignored, gena stays 0.
